// File: rtl/lock_sequence_ctrl_pkg.sv
// Shared types and constants for the six-digit lock sequencing controller.
//   state_e   : controller states
//   key_evt_t : registered keypad strobe bundle
//   max_u     : helper used to size the shared timer
package lock_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BUF_W      = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FAIL_W     = 3;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    typedef struct packed {
        logic               valid;
        logic               enter;
        logic               clear;
        logic [DIGIT_W-1:0] digit;
    } key_evt_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_sequence_ctrl_if.sv
// Keypad / display bundle between the keypad scanner, the lock controller and
// the display/latch driver.
//   master : keypad side (drives mode and key strobes, observes status)
//   slave  : controller side (consumes keys, drives disp/digit_cnt/status)
interface lock_sequence_ctrl_if;
    import lock_pkg::*;

    logic                 mode;
    logic                 key_valid;
    logic [DIGIT_W-1:0]   key_digit;
    logic                 key_enter;
    logic                 key_clear;
    logic [BUF_W-1:0]     disp;
    logic [CNT_W-1:0]     digit_cnt;
    logic                 unlock;
    logic                 alarm;
    logic                 err;
    logic                 prog_done;
    logic                 busy;

    modport master (
        output mode, key_valid, key_digit, key_enter, key_clear,
        input  disp, digit_cnt, unlock, alarm, err, prog_done, busy
    );

    modport slave (
        input  mode, key_valid, key_digit, key_enter, key_clear,
        output disp, digit_cnt, unlock, alarm, err, prog_done, busy
    );

endinterface

// File: rtl/lock_sequence_ctrl_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
// Holds at zero instead of wrapping; zero_o is registered and tracks the
// counter value (high whenever the count is 0).
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i this cycle
//   load_val_i  : value to load
//   zero_o      : count is zero
module lock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             zero_q;

    // Next count: load wins, otherwise decrement toward 0 and stay there
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/lock_sequence_ctrl.sv
// Sequencing controller for the six-digit electronic lock: collects keypad
// digits, programs or verifies the stored password, drives a timed unlock and
// an alarm lockout after repeated failures.
//   clk    : system clock
//   clr_n  : async active-low reset
//   bus    : keypad strobes in; disp, digit_cnt, unlock, alarm, err,
//            prog_done, busy out (all registered)
module lock_sequence_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned      UNLOCK_CYCLES = 50_000_000,
    parameter int unsigned      LOCK_CYCLES   = 500_000_000,
    parameter int unsigned      MAX_FAIL      = 3,
    parameter logic [BUF_W-1:0] DEFAULT_PW    = 24'h000000
) (
    input  logic                 clk,
    input  logic                 clr_n,
    lock_sequence_ctrl_if.slave  bus
);

    localparam int unsigned TIMER_W = $clog2(max_u(UNLOCK_CYCLES, LOCK_CYCLES) + 1);
    // Failure count at which the next miss triggers lockout
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(NUM_DIGITS);

    state_e             state_q, state_d;
    key_evt_t           key_q;
    logic               mode_q, mode_prev_q, mode_chg;
    logic [BUF_W-1:0]   disp_q, disp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   pw_q, pw_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic               unlock_q, unlock_d;
    logic               alarm_q, alarm_d;
    logic               err_q, err_d;
    logic               prog_done_q, prog_done_d;
    logic               busy_q, busy_d;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;

    lock_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (clr_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Input stage: keypad strobes and mode are registered before the FSM sees them
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            key_q       <= '0;
            mode_q      <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            key_q       <= '{valid: bus.key_valid, enter: bus.key_enter,
                             clear: bus.key_clear, digit: bus.key_digit};
            mode_q      <= bus.mode;
            mode_prev_q <= mode_q;
        end
    end

    assign mode_chg = (mode_q != mode_prev_q);

    // State, buffer, password and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            disp_q      <= '0;
            cnt_q       <= '0;
            pw_q        <= DEFAULT_PW;
            fail_q      <= '0;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
            prog_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            cnt_q       <= cnt_d;
            pw_q        <= pw_d;
            fail_q      <= fail_d;
            unlock_q    <= unlock_d;
            alarm_q     <= alarm_d;
            err_q       <= err_d;
            prog_done_q <= prog_done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        cnt_d       = cnt_q;
        pw_d        = pw_q;
        fail_d      = fail_q;
        unlock_d    = 1'b0;
        alarm_d     = 1'b0;
        err_d       = 1'b0;
        prog_done_d = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            IDLE, ENTRY: begin
                // Mode edge and clear both flush the buffer; clear > enter > digit
                if (mode_chg || key_q.clear) begin
                    disp_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (key_q.enter) begin
                    if (mode_q) begin
                        state_d = CHECK;
                    end else if (cnt_q == FULL_CNT) begin
                        pw_d        = disp_q;
                        prog_done_d = 1'b1;
                        fail_d      = '0;
                        disp_d      = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end else if (key_q.valid && (cnt_q < FULL_CNT) && (key_q.digit <= BCD_MAX)) begin
                    disp_d  = {disp_q[BUF_W-DIGIT_W-1:0], key_q.digit};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ENTRY;
                end
            end

            CHECK: begin
                disp_d = '0;
                cnt_d  = '0;
                if ((cnt_q == FULL_CNT) && (disp_q == pw_q)) begin
                    fail_d   = '0;
                    unlock_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(UNLOCK_CYCLES - 1);
                    state_d  = OPEN;
                end else if (fail_q >= FAIL_LIMIT) begin
                    fail_d   = fail_q + FAIL_W'(1);
                    alarm_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(LOCK_CYCLES - 1);
                    state_d  = LOCKOUT;
                end else begin
                    fail_d  = fail_q + FAIL_W'(1);
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            OPEN: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    unlock_d = 1'b1;
                end
            end

            LOCKOUT: begin
                if (tmr_zero) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    alarm_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CHECK) || (state_d == OPEN) || (state_d == LOCKOUT);
    end

    assign bus.disp      = disp_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.unlock    = unlock_q;
    assign bus.alarm     = alarm_q;
    assign bus.err       = err_q;
    assign bus.prog_done = prog_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lock_sequence_ctrl.sv
// Scoreboard bench for lock_sequence_ctrl: stimulus pushes expected output
// snapshots keyed by cycle; a negedge monitor pops and compares them and flags
// any unexpected unlock/alarm/err/prog_done activity.
module tb_lock_sequence_ctrl;
    import lock_pkg::*;

    localparam int unsigned UNLOCK_CYCLES = 4;
    localparam int unsigned LOCK_CYCLES   = 8;
    localparam int unsigned MAX_FAIL      = 3;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    lock_sequence_ctrl_if bus ();

    lock_sequence_ctrl #(
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .MAX_FAIL      (MAX_FAIL),
        .DEFAULT_PW    (24'h000000)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        unlock;
        logic        alarm;
        logic        err;
        logic        prog_done;
        logic        busy;
        logic [23:0] disp;
        logic [2:0]  cnt;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(input int c, input logic u, input logic a, input logic e,
                                input logic p, input logic b, input logic [23:0] d,
                                input logic [2:0] n);
        exp_t x;
        x.cyc = c; x.unlock = u; x.alarm = a; x.err = e;
        x.prog_done = p; x.busy = b; x.disp = d; x.cnt = n;
        return x;
    endfunction

    task automatic push(input exp_t e);
        int i;
        i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    // Monitor: compare every expected snapshot due this cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   seen;
        seen = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++; errors++;
            $display("FAIL missed_snapshot cyc=%0d (now %0d)", e.cyc, cyc);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            seen = 1'b1;
            checks++;
            if ({bus.unlock, bus.alarm, bus.err, bus.prog_done, bus.busy, bus.disp, bus.digit_cnt} !==
                {e.unlock, e.alarm, e.err, e.prog_done, e.busy, e.disp, e.cnt}) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got u=%b a=%b e=%b p=%b b=%b disp=%h cnt=%0d expected u=%b a=%b e=%b p=%b b=%b disp=%h cnt=%0d",
                         cyc, bus.unlock, bus.alarm, bus.err, bus.prog_done, bus.busy, bus.disp, bus.digit_cnt,
                         e.unlock, e.alarm, e.err, e.prog_done, e.busy, e.disp, e.cnt);
            end
        end
        if (!seen && (bus.unlock || bus.alarm || bus.err || bus.prog_done)) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse cyc=%0d got u=%b a=%b e=%b p=%b expected all 0",
                     cyc, bus.unlock, bus.alarm, bus.err, bus.prog_done);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        tick();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    task automatic press_seq(input logic [23:0] pw);
        for (int i = 5; i >= 0; i--) press(pw[i*4 +: 4]);
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
    endtask

    task automatic set_mode(input logic m);
        bus.mode = m;
        tick(4);
    endtask

    // Correct verify: unlock high for exactly UNLOCK_CYCLES from edge N+2
    task automatic verify_ok(input logic [23:0] pw);
        int n;
        press_seq(pw);
        n = cyc + 1;
        push(mk(n,     0, 0, 0, 0, 0, pw, 3'd6));
        push(mk(n + 1, 0, 0, 0, 0, 1, pw, 3'd6));
        for (int k = 2; k <= 5; k++) push(mk(n + k, 1, 0, 0, 0, 1, 24'h0, 3'd0));
        push(mk(n + 6, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        enter();
        tick(7);
    endtask

    // Wrong verify: err pulse, or a full lockout with ignored digits
    task automatic verify_bad(input logic [23:0] pw, input bit lock);
        int n;
        press_seq(pw);
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 0, 1, pw, 3'd6));
        if (!lock) begin
            push(mk(n + 2, 0, 0, 1, 0, 0, 24'h0, 3'd0));
            push(mk(n + 3, 0, 0, 0, 0, 0, 24'h0, 3'd0));
            enter();
            tick(4);
        end else begin
            for (int k = 2; k <= 9; k++) push(mk(n + k, 0, 1, 0, 0, 1, 24'h0, 3'd0));
            push(mk(n + 10, 0, 0, 0, 0, 0, 24'h0, 3'd0));
            enter();
            tick(2);
            press(4'd5);
            press(4'd7);
            tick(7);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bus.mode      = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        tick(3);
        clr_n = 1'b1;
        push(mk(cyc + 1, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        tick(4);

        // Default password opens the lock
        verify_ok(24'h000000);

        // Program 123456, then verify it and reject the old password
        set_mode(1'b0);
        press_seq(24'h123456);
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 1, 0, 24'h0, 3'd0));
        push(mk(n + 2, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        enter();
        tick(3);
        set_mode(1'b1);
        verify_ok(24'h123456);
        verify_bad(24'h000000, 1'b0);
        verify_ok(24'h123456);

        // Three misses: err, err, lockout; afterwards fail count is back to 0
        verify_bad(24'h111111, 1'b0);
        verify_bad(24'h111111, 1'b0);
        verify_bad(24'h111111, 1'b1);
        verify_bad(24'h111111, 1'b0);
        verify_bad(24'h111111, 1'b0);
        verify_ok(24'h123456);

        // Overfill and an invalid digit, then clear beats enter in the same cycle
        for (int d = 1; d <= 7; d++) press(4'(d));
        press(4'd12);
        push(mk(cyc + 1, 0, 0, 0, 0, 0, 24'h123456, 3'd6));
        n = cyc + 1;
        bus.key_clear = 1'b1;
        bus.key_enter = 1'b1;
        push(mk(n + 1, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        push(mk(n + 2, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        tick();
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        tick(3);

        // Short entry: failure in verify mode
        for (int d = 1; d <= 5; d++) press(4'(d));
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 0, 1, 24'h012345, 3'd5));
        push(mk(n + 2, 0, 0, 1, 0, 0, 24'h0, 3'd0));
        push(mk(n + 3, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        enter();
        tick(4);

        // Short entry: ignored in program mode
        set_mode(1'b0);
        for (int d = 1; d <= 5; d++) press(4'(d));
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 0, 0, 24'h012345, 3'd5));
        push(mk(n + 2, 0, 0, 0, 0, 0, 24'h012345, 3'd5));
        enter();
        tick(3);
        bus.key_clear = 1'b1;
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        tick();
        bus.key_clear = 1'b0;
        tick(2);
        set_mode(1'b1);
        verify_ok(24'h123456);

        // Reset during OPEN cycle 2: unlock drops at once, password restored
        press_seq(24'h123456);
        n = cyc + 1;
        push(mk(n + 1, 0, 0, 0, 0, 1, 24'h123456, 3'd6));
        push(mk(n + 2, 1, 0, 0, 0, 1, 24'h0, 3'd0));
        push(mk(n + 3, 0, 0, 0, 0, 0, 24'h0, 3'd0));
        enter();
        tick(3);
        clr_n = 1'b0;
        tick(2);
        clr_n = 1'b1;
        tick(4);
        verify_bad(24'h123456, 1'b0);
        verify_ok(24'h000000);

        tick(3);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover_expectations got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
